gemm_buf_ctrl: RTL and testbench

Sequencer for the GEMM staging buffers: src_buf (16 x 64-bit words, read as 32 x 32-bit elements) and dst_buf (16 x 32-bit results, drained as 8 x 64-bit words).
- Phase 1: loads src_buf from a 64-bit input stream.
- Phase 2: sweeps the element index for each output row while the MAC core accumulates.
- Phase 3: writes each row result into dst_buf.
- Phase 4: drains dst_buf to a 64-bit output stream under backpressure.
- Sits between the DMA stream interfaces and the buffer/core datapath. Load and drain never overlap compute, so buffer port-priority conflicts cannot occur.

---
 rtl/gemm_buf_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_gemm_buf_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_buf_ctrl.sv
// GEMM staging-buffer sequencer: loads src_buf from the input stream, sweeps the
// MAC core over every row, strobes row results into dst_buf, then drains dst_buf.
module gemm_buf_ctrl #(
  parameter int unsigned SRC_WORDS = 16,
  parameter int unsigned N_ELEM    = 32,
  parameter int unsigned N_ROWS    = 16,
  parameter int unsigned CORE_LAT  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [63:0]                     s_data,
  input  logic                            s_last,
  output logic                            src_v,
  output logic [$clog2(SRC_WORDS)-1:0]    src_a,
  output logic [63:0]                     src_d,
  output logic                            exec,
  output logic [$clog2(N_ELEM)-1:0]       ia,
  output logic [$clog2(N_ROWS)-1:0]       row,
  output logic                            acc_clr,
  output logic                            outr,
  output logic [$clog2(N_ROWS)-1:0]       oa,
  output logic                            dst_v,
  output logic [$clog2(N_ROWS/2)-1:0]     dst_a,
  input  logic [63:0]                     dst_d,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [63:0]                     m_data,
  output logic                            m_last
);

  localparam int unsigned SAW       = $clog2(SRC_WORDS);
  localparam int unsigned IAW       = $clog2(N_ELEM);
  localparam int unsigned RW        = $clog2(N_ROWS);
  localparam int unsigned DST_WORDS = N_ROWS / 2;
  localparam int unsigned DAW       = $clog2(DST_WORDS);
  localparam logic [DAW:0] RD_END   = (DAW+1)'(DST_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_FLUSH,
    S_DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic           err_q, err_d;
  logic [SAW-1:0] ld_cnt_q, ld_cnt_d;
  logic [IAW-1:0] ia_q, ia_d;
  logic [RW-1:0]  row_q, row_d;
  logic [DAW:0]   rd_cnt_q, rd_cnt_d;
  logic           clr_pipe;

  logic           pipe_v_q   [CORE_LAT];
  logic [RW-1:0]  pipe_row_q [CORE_LAT];

  logic [63:0]    buf_data_q [2];
  logic           buf_last_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     cnt_q;
  logic           infl_q, infl_last_q;

  logic           ld_last, ia_last, head_last, pop, room;
  logic [1:0]     occ;

  assign ld_last   = (ld_cnt_q == SAW'(SRC_WORDS - 1));
  assign ia_last   = (ia_q == IAW'(N_ELEM - 1));
  assign head_last = buf_last_q[rd_ptr_q];

  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;
  assign src_a   = ld_cnt_q;
  assign src_d   = s_data;
  assign ia      = ia_q;
  assign row     = row_q;
  assign acc_clr = exec & (ia_q == '0);
  assign outr    = pipe_v_q[CORE_LAT-1];
  assign oa      = pipe_row_q[CORE_LAT-1];
  assign dst_a   = rd_cnt_q[DAW-1:0];
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = buf_data_q[rd_ptr_q];
  assign m_last  = m_valid & head_last;
  assign pop     = m_valid & m_ready;
  assign done    = pop & head_last;

  // A beat leaving this cycle frees a slot, which keeps 1 beat/cycle under full ready.
  assign occ  = cnt_q + {1'b0, infl_q};
  assign room = (occ < 2'd2) | pop;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    ld_cnt_d = ld_cnt_q;
    ia_d     = ia_q;
    row_d    = row_q;
    rd_cnt_d = rd_cnt_q;
    clr_pipe = 1'b0;
    s_ready  = 1'b0;
    src_v    = 1'b0;
    exec     = 1'b0;
    dst_v    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          err_d    = 1'b0;
          ld_cnt_d = '0;
          ia_d     = '0;
          row_d    = '0;
          rd_cnt_d = '0;
          clr_pipe = 1'b1;
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          src_v    = 1'b1;
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (s_last != ld_last) err_d = 1'b1;
          if (ld_last) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec = 1'b1;
        if (ia_last) begin
          ia_d  = '0;
          row_d = row_q + 1'b1;
          if (row_q == RW'(N_ROWS - 1)) state_d = S_FLUSH;
        end else begin
          ia_d = ia_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (outr) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((rd_cnt_q != RD_END) && room) begin
          dst_v    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      ld_cnt_q <= '0;
      ia_q     <= '0;
      row_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      ld_cnt_q <= ld_cnt_d;
      ia_q     <= ia_d;
      row_q    <= row_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Last-element flag and row ride a CORE_LAT-deep pipe to line up with the core result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CORE_LAT; i++) begin
        pipe_v_q[i]   <= 1'b0;
        pipe_row_q[i] <= '0;
      end
    end else if (clr_pipe) begin
      for (int unsigned i = 0; i < CORE_LAT; i++) begin
        pipe_v_q[i]   <= 1'b0;
        pipe_row_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0]   <= exec & ia_last;
      pipe_row_q[0] <= row_q;
      for (int unsigned i = 1; i < CORE_LAT; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_row_q[i] <= pipe_row_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q        <= 1'b0;
      infl_last_q   <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
    end else begin
      infl_q      <= dst_v;
      infl_last_q <= dst_v & (dst_a == DAW'(DST_WORDS - 1));
      if (infl_q) begin
        buf_data_q[wr_ptr_q] <= dst_d;
        buf_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_gemm_buf_ctrl.sv
// Bench for gemm_buf_ctrl: a table of job configurations, each run cycle by cycle
// against timing and data expectations computed from job-relative cycle offsets.
module tb_gemm_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        src_v;
  logic [3:0]  src_a;
  logic [63:0] src_d;
  logic        exec;
  logic [4:0]  ia;
  logic [3:0]  row;
  logic        acc_clr, outr;
  logic [3:0]  oa;
  logic        dst_v;
  logic [2:0]  dst_a;
  logic [63:0] dst_d = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic        m_last;

  int tests = 0;
  int fails = 0;
  bit err_m;
  logic [63:0] dst_mem [8];

  gemm_buf_ctrl #(.SRC_WORDS(16), .N_ELEM(32), .N_ROWS(16), .CORE_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .src_v(src_v), .src_a(src_a), .src_d(src_d), .exec(exec), .ia(ia), .row(row),
    .acc_clr(acc_clr), .outr(outr), .oa(oa), .dst_v(dst_v), .dst_a(dst_a),
    .dst_d(dst_d), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  // dst_buf stand-in: one-cycle read latency, junk on cycles with no read.
  always @(posedge clk) begin
    if (dst_v) dst_d <= dst_mem[dst_a];
    else       dst_d <= {$urandom, $urandom};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {33'b0, busy, done, err, s_ready, src_v, src_a, exec, ia, row, acc_clr,
            outr, oa, dst_v, dst_a, m_valid, m_last};
  endfunction

  task automatic run_job(input int err_beat, input int rmode, input int vmode,
                         input bit abort);
    logic [63:0] data;
    int b, k, n, d;
    bit ev, rdy;
    for (int i = 0; i < 8; i++) dst_mem[i] = {$urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    err_m = 1'b0;

    b = 0;
    k = 0;
    while (b < 16 && k < 200) begin
      ev = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      data = {$urandom, $urandom};
      s_valid = ev;
      s_data  = data;
      s_last  = ((b == 15) != (b == err_beat));
      @(negedge clk);
      chk("load_busy", 64'(busy), 64'd1);
      chk("load_s_ready", 64'(s_ready), 64'd1);
      chk("load_exec", 64'(exec), 64'd0);
      chk("load_src_v", 64'(src_v), 64'(ev));
      chk("load_err", 64'(err), 64'(err_m));
      if (ev) begin
        chk("load_src_a", 64'(src_a), 64'(b));
        chk("load_src_d", src_d, data);
        if (s_last != (b == 15)) err_m = 1'b1;
        b++;
      end
      @(posedge clk); #1;
      k++;
    end
    chk("load_beats", 64'(b), 64'd16);
    s_last = 1'b0;

    // k counts cycles from the one after the final load beat.
    for (k = 0; k < 515; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      start   = (k == 100);
      @(negedge clk);
      ev = (k < 512);
      chk("exec", 64'(exec), 64'(ev));
      chk("exec_busy", 64'(busy), 64'd1);
      chk("exec_s_ready", 64'(s_ready), 64'd0);
      chk("exec_src_v", 64'(src_v), 64'd0);
      chk("exec_dst_v", 64'(dst_v), 64'd0);
      chk("exec_m_valid", 64'(m_valid), 64'd0);
      chk("exec_err", 64'(err), 64'(err_m));
      if (ev) begin
        chk("ia", 64'(ia), 64'(k % 32));
        chk("row", 64'(row), 64'(k / 32));
        chk("acc_clr", 64'(acc_clr), 64'(k % 32 == 0));
      end
      ev = (k >= 34) && ((k - 34) % 32 == 0);
      chk("outr", 64'(outr), 64'(ev));
      if (ev) chk("oa", 64'(oa), 64'((k - 34) / 32));
      if (abort && k == 5 * 32 + 3) begin
        s_valid = 1'b0;
        start   = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("abort_outs_zero", outs_vec(), 64'd0);
        chk("abort_m_data_zero", m_data, 64'd0);
        @(posedge clk); #1;
        chk("abort_hold_zero", outs_vec(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release_idle", outs_vec(), 64'd0);
        @(posedge clk); #1;
        err_m = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    start   = 1'b0;
    s_valid = 1'b0;

    n = 0;
    d = 0;
    while (n < 8 && d < 300) begin
      if (rmode == 0)                       rdy = 1'b1;
      else if (rmode == 2 && d >= 4 && d < 14) rdy = 1'b0;
      else                                  rdy = 1'($urandom_range(0, 1));
      m_ready = rdy;
      @(negedge clk);
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_exec", 64'(exec), 64'd0);
      chk("drain_outr", 64'(outr), 64'd0);
      chk("drain_s_ready", 64'(s_ready), 64'd0);
      chk("drain_err", 64'(err), 64'(err_m));
      if (rmode == 0) chk("drain_m_valid", 64'(m_valid), 64'(d >= 2 && d <= 9));
      if (m_valid) begin
        chk("m_data", m_data, dst_mem[n]);
        chk("m_last", 64'(m_last), 64'(n == 7));
        chk("done", 64'(done), 64'(rdy && n == 7));
        if (rdy) n++;
      end else begin
        chk("done_idle", 64'(done), 64'd0);
      end
      @(posedge clk); #1;
      d++;
    end
    chk("drain_beats", 64'(n), 64'd8);
    m_ready = 1'b0;
    @(negedge clk);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_m_valid", 64'(m_valid), 64'd0);
    chk("post_done", 64'(done), 64'd0);
    chk("post_err", 64'(err), 64'(err_m));
    @(posedge clk); #1;
  endtask

  typedef struct {
    int err_beat;
    int rmode;
    int vmode;
    bit abort;
    bit exp_err;
  } job_t;

  job_t jobs [7];

  initial begin
    jobs[0] = '{err_beat: 9,  rmode: 0, vmode: 0, abort: 1'b1, exp_err: 1'b0};
    jobs[1] = '{err_beat: -1, rmode: 0, vmode: 0, abort: 1'b0, exp_err: 1'b0};
    jobs[2] = '{err_beat: 9,  rmode: 1, vmode: 0, abort: 1'b0, exp_err: 1'b1};
    jobs[3] = '{err_beat: -1, rmode: 2, vmode: 1, abort: 1'b0, exp_err: 1'b0};
    jobs[4] = '{err_beat: 15, rmode: 0, vmode: 1, abort: 1'b0, exp_err: 1'b1};
    jobs[5] = '{err_beat: 0,  rmode: 1, vmode: 1, abort: 1'b0, exp_err: 1'b1};
    jobs[6] = '{err_beat: -1, rmode: 2, vmode: 1, abort: 1'b0, exp_err: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_zero", outs_vec(), 64'd0);
    chk("reset_m_data_zero", m_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < 7; j++) begin
      run_job(jobs[j].err_beat, jobs[j].rmode, jobs[j].vmode, jobs[j].abort);
      @(negedge clk);
      chk($sformatf("job%0d_err", j), 64'(err), 64'(jobs[j].exp_err));
      chk($sformatf("job%0d_idle", j), 64'(busy), 64'd0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
